// File: rtl/alu_pkg.sv
// Shared constants for the iterative RV32M divider: funct3[1:0] opcodes,
// FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem,
  input  logic            msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // One extra bit keeps the shifted remainder exact for divisors above 2^(XLEN-1);
  // the top bit of the difference is then a clean borrow flag.
  assign shifted  = {rem, msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[XLEN];
  assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/alu_div.sv
// Iterative DIV/DIVU/REM/REMU unit with valid/ready handshakes on both sides.
// Define ALU_DIV_EARLY_OUT_EN to finish divide-by-zero and overflow cases after one cycle.
module alu_div
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_CLK,
  input  logic            i_RST_n,
  input  logic            i_VALID,
  output logic            o_READY,
  input  logic [XLEN-1:0] i_OP1,
  input  logic [XLEN-1:0] i_OP2,
  input  logic [1:0]      i_OPCODE,
  input  logic            i_FLUSH,
  output logic            o_VALID,
  input  logic            i_READY,
  output logic [XLEN-1:0] o_RES
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] op1_raw;
  logic [1:0]      opcode;
  logic            negate_q;
  logic            negate_r;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] res;

  logic            in_signed;
  logic            sign1;
  logic            sign2;
  logic            accept;
  logic            finish;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] quot_next;

  assign in_signed = ~i_OPCODE[0];
  assign sign1     = in_signed & i_OP1[XLEN-1];
  assign sign2     = in_signed & i_OP2[XLEN-1];
  assign accept    = i_VALID & o_READY & ~i_FLUSH;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .msb      (dividend[XLEN-1]),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign quot_next = {quot[XLEN-2:0], step_q};

`ifdef ALU_DIV_EARLY_OUT_EN
  assign finish = (cnt == CW'(XLEN - 1)) | div0 | ovf;
`else
  assign finish = (cnt == CW'(XLEN - 1));
`endif

  // Final sign fix-up plus the RISC-V mandated results for x/0 and MIN/-1.
  function automatic logic [XLEN-1:0] pick_result(
    input logic [1:0]      op,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic            nq,
    input logic            nr,
    input logic            d0,
    input logic            ov,
    input logic [XLEN-1:0] raw
  );
    logic [XLEN-1:0] value;
    if (op[1]) begin
      if (d0)      value = raw;
      else if (ov) value = '0;
      else         value = nr ? (~r + 1'b1) : r;
    end else begin
      if (d0)      value = '1;
      else if (ov) value = MIN_INT;
      else         value = nq ? (~q + 1'b1) : q;
    end
    return value;
  endfunction

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state    <= IDLE;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      dividend <= '0;
      op1_raw  <= '0;
      opcode   <= '0;
      negate_q <= 1'b0;
      negate_r <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      res      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dividend <= sign1 ? (~i_OP1 + 1'b1) : i_OP1;
            divisor  <= sign2 ? (~i_OP2 + 1'b1) : i_OP2;
            negate_q <= sign1 ^ sign2;
            negate_r <= sign1;
            opcode   <= i_OPCODE;
            op1_raw  <= i_OP1;
            div0     <= (i_OP2 == '0);
            ovf      <= in_signed & (i_OP1 == MIN_INT) & (&i_OP2);
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (i_FLUSH) begin
            state <= IDLE;
          end else begin
            rem      <= step_rem;
            quot     <= quot_next;
            dividend <= {dividend[XLEN-2:0], 1'b0};
            cnt      <= cnt + 1'b1;
            if (finish) begin
              res   <= pick_result(opcode, quot_next, step_rem, negate_q, negate_r,
                                   div0, ovf, op1_raw);
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (i_FLUSH || i_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_READY = (state == IDLE);
  assign o_VALID = (state == DONE);
  assign o_RES   = res;

endmodule

// File: tb/tb_alu_div.sv
// Directed bench for alu_div: arithmetic corner cases, latency, backpressure,
// flush and asynchronous reset, with hand-computed expected values.
module tb_alu_div;
  import alu_pkg::*;

`ifdef ALU_DIV_EARLY_OUT_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [1:0]  opcode;
  logic        flush;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] res;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_div #(.XLEN(32)) dut (
    .i_CLK    (clk),
    .i_RST_n  (rst_n),
    .i_VALID  (in_valid),
    .o_READY  (out_ready),
    .i_OP1    (op1),
    .i_OP2    (op2),
    .i_OPCODE (opcode),
    .i_FLUSH  (flush),
    .o_VALID  (out_valid),
    .i_READY  (in_ready),
    .o_RES    (res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1      = 32'hDEAD_BEEF;
    op2      = 32'h0000_0001;
    opcode   = ~op;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat,
                     input int hold);
    int cycles;
    issue(op, a, b);
    wait_valid(cycles);
    check({tag, " latency"}, cycles, lat);
    check(tag, res, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold res"}, res, exp);
      check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " hold ready"}, {31'd0, out_ready}, 32'd0);
    end
    @(negedge clk);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    check({tag, " drained valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " drained ready"}, {31'd0, out_ready}, 32'd1);
    $display("op %0d a=%h b=%h -> res=%h latency=%0d (%s)", op, a, b, exp, cycles, tag);
  endtask

  initial begin
    int seen;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    flush    = 1'b0;
    op1      = '0;
    op2      = '0;
    opcode   = '0;
    #12;
    check("reset ready", {31'd0, out_ready}, 32'd1);
    check("reset valid", {31'd0, out_valid}, 32'd0);
    check("reset res", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
    run("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 32, 0);
    run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0);
    run("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0);
    run("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32, 0);
    run("div -100/-7", DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32, 0);
    run("rem -100/-7", REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32, 0);
    run("divu big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32, 0);
    run("remu big", REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32, 0);
    run("div by 0", DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, LAT0, 0);
    run("rem by 0", REM, 32'h1234_5678, 32'd0, 32'h1234_5678, LAT0, 0);
    run("divu by 0", DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, LAT0, 0);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT0, 0);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT0, 0);
    run("divu min/-1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32, 0);
    run("backpressure", DIVU, 32'd100, 32'd7, 32'd14, 32, 5);

    // Flush during CALC at cnt=10: the aborted op must never raise o_VALID.
    issue(DIVU, 32'd1000, 32'd10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush ready", {31'd0, out_ready}, 32'd1);
    check("flush valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush no result", seen, 32'd0);
    $display("flush mid-calc: valid cycles after flush=%0d", seen);

    // Flush in IDLE must block acceptance.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    opcode   = DIVU;
    op1      = 32'd50;
    op2      = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("idle flush blocks", {31'd0, out_ready}, 32'd1);
    $display("idle flush: ready=%0d", out_ready);
    run("divu 9/3 after flush", DIVU, 32'd9, 32'd3, 32'd3, 32, 0);

    // Asynchronous reset mid-CALC.
    issue(DIVU, 32'd1000, 32'd10);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst ready", {31'd0, out_ready}, 32'd1);
    check("async rst valid", {31'd0, out_valid}, 32'd0);
    check("async rst res", res, 32'd0);
    $display("async reset mid-calc: ready=%0d valid=%0d res=%h", out_ready, out_valid, res);
    @(negedge clk);
    rst_n = 1'b1;
    run("divu 9/3 after reset", DIVU, 32'd9, 32'd3, 32'd3, 32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
